// File: rtl/buf_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output word drained by valid/ready.
// The search starts at ptr, so the most recently granted requester has the lowest priority.
module buf_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e        state_q;
  logic [W-1:0]  data_q;
  logic [SW-1:0] src_q;
  logic [SW-1:0] ptr_q;

  logic [SW-1:0] winner;
  logic          found;
  logic          load;

  // Scan N positions starting at ptr_q; the first pending requester wins.
  always_comb begin
    int unsigned idx_wide;
    logic [SW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_wide = (int'(ptr_q) + k) % N;
      idx      = SW'(idx_wide);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign load = found && ((state_q == StEmpty) || out_ready) && rst_n;

  always_comb begin
    gnt = '0;
    if (load) begin
      gnt[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (load) begin
            state_q <= StFull;
          end
        end
        StFull: begin
          if (!load && out_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
      if (load) begin
        data_q <= req_data[winner*W +: W];
        src_q  <= winner;
        ptr_q  <= (winner == SW'(N - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule
